// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone B4 classic arbiter with round-robin grant
// held for the owner's whole CYC, and a stall watchdog that turns a lost ACK into ERR.
module wb_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  input  logic [3:0]  M0_SEL_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  output logic [31:0] M0_DAT_O,
  output logic        M0_ACK_O,
  output logic        M0_ERR_O,
  input  logic [31:0] M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  input  logic [3:0]  M1_SEL_I,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  output logic [31:0] M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        M1_ERR_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  // Handshake: a beat completes on any edge where the owner's STB and ACK_I are
  // both high; the grant itself is held until the owner lowers CYC.
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_t           state;
  logic             owner;
  logic             last;
  logic             err_q;
  logic [CNT_W-1:0] wdog;

  logic granted;
  logic own_cyc;
  logic own_stb;

  assign granted = (state == OWN0) || (state == OWN1);
  assign own_cyc = owner ? M1_CYC_I : M0_CYC_I;
  assign own_stb = owner ? M1_STB_I : M0_STB_I;

  always_comb begin
    ADR_O = '0;
    DAT_O = '0;
    SEL_O = '0;
    WE_O  = 1'b0;
    CYC_O = 1'b0;
    STB_O = 1'b0;
    if (granted) begin
      if (owner) begin
        ADR_O = M1_ADR_I;
        DAT_O = M1_DAT_I;
        SEL_O = M1_SEL_I;
        WE_O  = M1_WE_I;
        CYC_O = M1_CYC_I;
        STB_O = M1_STB_I;
      end else begin
        ADR_O = M0_ADR_I;
        DAT_O = M0_DAT_I;
        SEL_O = M0_SEL_I;
        WE_O  = M0_WE_I;
        CYC_O = M0_CYC_I;
        STB_O = M0_STB_I;
      end
    end
  end

  assign M0_DAT_O = DAT_I;
  assign M1_DAT_O = DAT_I;
  assign M0_ACK_O = (state == OWN0) && ACK_I;
  assign M1_ACK_O = (state == OWN1) && ACK_I;
  // ERR only exists in the first FLUSH cycle, where ACK is already blocked.
  assign M0_ERR_O = err_q && (state == FLUSH) && !owner;
  assign M1_ERR_O = err_q && (state == FLUSH) &&  owner;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (M0_CYC_I && (!M1_CYC_I || last)) begin
            state <= OWN0;
            owner <= 1'b0;
          end else if (M1_CYC_I) begin
            state <= OWN1;
            owner <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state <= IDLE;
            last  <= owner;
            wdog  <= '0;
          end else if (own_stb && !ACK_I) begin
            if (TIMEOUT != 0 && wdog == WDOG_LAST) begin
              state <= FLUSH;
              err_q <= 1'b1;
              wdog  <= '0;
            end else begin
              wdog <= wdog + CNT_W'(1);
            end
          end else begin
            wdog <= '0;
          end
        end
        FLUSH: begin
          if (!own_cyc) begin
            state <= IDLE;
            last  <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter between the CPU instruction-fetch port (M0) and the load/store bus unit (M1), and the shared system bus to RAM and devices.
- Round-robin grant, locked for the full duration of the owner's CYC.
- A per-transfer watchdog converts a missing slave ACK into ERR to the owning master, so the CPU never hangs.

Parameters:
- TIMEOUT, 255, cycles with STB asserted and no ACK before the watchdog fires; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  reset; synchronous and active-high.
- M0_ADR_I, M1_ADR_I  in  32  master address.
- M0_DAT_I, M1_DAT_I  in  32  master write data.
- M0_SEL_I, M1_SEL_I  in  4  byte select.
- M0_CYC_I, M1_CYC_I  in  1  cycle request.
- M0_STB_I, M1_STB_I  in  1  strobe.
- M0_WE_I, M1_WE_I  in  1  write enable.
- M0_DAT_O, M1_DAT_O  out  32  read data; both equal DAT_I.
- M0_ACK_O, M1_ACK_O  out  1  acknowledge, delivered to the owner only.
- M0_ERR_O, M1_ERR_O  out  1  watchdog error, delivered to the owner only.
- ADR_O  out  32  slave address.
- DAT_O  out  32  slave write data.
- SEL_O  out  4  slave byte select.
- CYC_O  out  1  slave cycle.
- STB_O  out  1  slave strobe.
- WE_O  out  1  slave write enable.
- DAT_I  in  32  slave read data.
- ACK_I  in  1  slave acknowledge.

Behaviour:
- State register values: IDLE, OWN0, OWN1, FLUSH. Registers: state, owner (1 bit), last (1 bit), wdog (CNT_W bits).
- Reset (RST_I high at an edge) sets state=IDLE, last=1, wdog=0. This applies mid-transfer as well: no ACK_O or ERR_O is forwarded in the cycle following reset.
- Slave outputs are combinational from the state:
  - In OWN0 and OWN1, ADR_O/DAT_O/SEL_O/WE_O mirror the owner's inputs. CYC_O = owner CYC_I and STB_O = owner STB_I.
  - In IDLE and FLUSH, CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0.
- ACK_O and ERR_O:
  - Mx_ACK_O = ACK_I while in OWNx, else 0.
  - Mx_ERR_O is asserted for exactly one cycle when the watchdog fires.
  - ACK_O and ERR_O are never both high.
- IDLE:
  - Samples M0_CYC_I and M1_CYC_I.
  - Only one requesting: go to that OWNx.
  - Both requesting: grant the master with index != last.
  - Neither requesting: stay in IDLE.
  - Grant latency is one cycle: request at edge n, slave CYC_O high during cycle n+1.
- OWNx:
  - Owner CYC_I low at an edge: go to IDLE, set last=x, wdog=0. There is always one idle bus cycle between grants; no back-to-back handover.
  - The non-owner's requests are ignored; its ACK_O and ERR_O stay 0.
- Watchdog:
  - In OWNx, if STB_O=1 and ACK_I=0, wdog increments.
  - ACK_I=1 or STB_O=0 clears wdog.
  - When TIMEOUT!=0 and wdog==TIMEOUT-1 with STB_O=1 and ACK_I=0:
    - next cycle Mx_ERR_O=1 for one cycle;
    - state goes to FLUSH;
    - slave CYC_O/STB_O are forced low from that cycle onward.
  - A late ACK_I arriving in FLUSH is discarded.
- FLUSH: wait until owner CYC_I=0, then go to IDLE with last=x.
- Simultaneous events:
  - ACK_I on the same edge the watchdog would fire: ACK wins; no ERR; wdog clears.
  - Owner dropping CYC_I while ACK_I is high: the ACK for the final beat is still forwarded in that cycle.
- Pipelined burst holding CYC with multiple STB beats: ownership is retained across beats; wdog clears per beat.

Test Plan:
- Reset, then M0 read at 0x100 with slave ACK after 2 cycles, DAT_I=0xCAFEBABE -> CYC_O high one cycle after request, ADR_O=0x100, M0_ACK_O pulses once with M0_DAT_O=0xCAFEBABE, M1_ACK_O stays 0.
- M0 and M1 both raise CYC on the same edge after reset -> M0 granted first (last=1). After M0 drops CYC, one idle cycle, then M1 granted with ADR_O = M1_ADR_I.
- Continuous requests from both masters over 6 transfers -> grant order strictly alternates 0,1,0,1,0,1.
- TIMEOUT=4, M1 write to 0x2000 with ACK_I held 0 -> M1_ERR_O pulses once after 4 stalled cycles, CYC_O drops, a later ACK_I is not forwarded, and IDLE is reached after M1 drops CYC.
- RST_I asserted in the middle of an M0 transfer while ACK_I is high -> next cycle CYC_O=0 and M0_ACK_O=0; a following M0 request is granted normally.
- M0 burst of 3 STB beats under a single CYC, each ACKed after 3 cycles, TIMEOUT=4 -> no ERR, M1 request blocked until M0 drops CYC.
